// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle M-extension sequencer for the EX stage.
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// While an op is in flight the pipeline is held via STALL. The result is
// presented for a single cycle on DONE and RESULT keeps that value afterwards.
//
// Ports:
//   CLK    - clock, rising edge
//   RESET  - synchronous, active-high reset
//   START  - EX-stage instruction valid
//   ALU_OP - op code from the control unit (MD ops live at ALU_OP[4:3]=2'b11)
//   DATA1  - rs1 operand
//   DATA2  - rs2 operand
//   FLUSH  - kill the in-flight op (branch taken / trap)
//   STALL  - freeze IF/ID/EX pipeline registers
//   DONE   - RESULT valid this cycle
//   RESULT - mul/div/rem result
//   BUSY   - sequencer is not idle
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALU_OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_e;

  localparam logic [4:0] OP_MUL    = 5'b11000;
  localparam logic [4:0] OP_MULH   = 5'b11001;
  localparam logic [4:0] OP_MULHSU = 5'b11010;
  localparam logic [4:0] OP_MULHU  = 5'b11011;
  localparam logic [4:0] OP_DIV    = 5'b11100;
  localparam logic [4:0] OP_REM    = 5'b11101;
  localparam logic [4:0] OP_FWD    = 5'b11110;
  localparam logic [4:0] OP_REMU   = 5'b11111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [4:0]        op_q;
  logic              neg_q;   // product / quotient must be negated
  logic              neg_r;   // remainder takes dividend sign
  logic [XLEN-1:0]   opnd;    // |multiplicand| or |divisor|
  logic [2*XLEN-1:0] acc;     // mul: {hi, lo}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_nxt;

  // Input decode
  logic            md_op;
  logic            accept;
  logic            is_div_in;
  logic            signed_a_in, signed_b_in;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_res;
  logic              last_iter;

  always_comb begin
    md_op       = (ALU_OP[4:3] == 2'b11) && (ALU_OP != OP_FWD);
    is_div_in   = ALU_OP[2];
    signed_a_in = (ALU_OP != OP_MULHU) && (ALU_OP != OP_REMU);
    signed_b_in = (ALU_OP == OP_MUL) || (ALU_OP == OP_MULH) ||
                  (ALU_OP == OP_DIV) || (ALU_OP == OP_REM);
    sign_a      = signed_a_in & DATA1[XLEN-1];
    sign_b      = signed_b_in & DATA2[XLEN-1];
    abs_a       = sign_a ? -DATA1 : DATA1;
    abs_b       = sign_b ? -DATA2 : DATA2;
    div_zero    = (DATA2 == '0);
    div_ovf     = ((ALU_OP == OP_DIV) || (ALU_OP == OP_REM)) &&
                  (DATA1 == INT_MIN) && (DATA2 == '1);
    special     = is_div_in & (div_zero | div_ovf);
    if (div_zero) begin
      special_res = (ALU_OP == OP_DIV) ? '1 : DATA1;
    end else begin
      special_res = (ALU_OP == OP_DIV) ? INT_MIN : '0;
    end
  end

  // One iteration. The multiplier sits in the low half and is shifted out
  // LSB-first while partial sums enter at the top; the divider shifts the
  // dividend MSB into the remainder and shifts quotient bits in at the LSB.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // remainder < divisor, so the difference always fits in XLEN bits
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (op_q[2]) begin
      acc_nxt = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV:                       final_res = neg_q ? -quo : quo;
      default:                      final_res = neg_r ? -rem : rem;  // REM, REMU
    endcase
  end

  assign last_iter = (cnt == CNT_W'(XLEN-1));

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = START & md_op & (state == S_IDLE) & ~FLUSH;
    STALL     = accept | (state == S_CALC);
    DONE      = (state == S_FIN);
    BUSY      = (state != S_IDLE);
    if (FLUSH) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = special ? S_FIN : S_CALC;
        S_CALC:  if (last_iter) state_nxt = S_FIN;
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      RESULT <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            op_q  <= ALU_OP;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            if (is_div_in) begin
              opnd <= abs_b;
              acc  <= {{XLEN{1'b0}}, abs_a};
            end else begin
              opnd <= abs_a;
              acc  <= {{XLEN{1'b0}}, abs_b};
            end
            if (special) RESULT <= special_res;
          end
        end
        S_CALC: begin
          if (!FLUSH) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last_iter) RESULT <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a table of directed vectors plus
// hand-written sequences for flush, reset, back-to-back and non-MD ops.
module tb_muldiv_seq;

  localparam logic [4:0] OP_MUL    = 5'b11000;
  localparam logic [4:0] OP_MULH   = 5'b11001;
  localparam logic [4:0] OP_MULHSU = 5'b11010;
  localparam logic [4:0] OP_MULHU  = 5'b11011;
  localparam logic [4:0] OP_DIV    = 5'b11100;
  localparam logic [4:0] OP_REM    = 5'b11101;
  localparam logic [4:0] OP_REMU   = 5'b11111;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [4:0]  ALU_OP;
  logic [31:0] DATA1, DATA2;
  logic        STALL, DONE, BUSY;
  logic [31:0] RESULT;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ALU_OP(ALU_OP),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .STALL(STALL), .DONE(DONE), .RESULT(RESULT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Presents an op, holds START until DONE (as a stalled pipeline would),
  // and reports the result, the DONE cycle relative to accept, and whether
  // STALL was high on every cycle before DONE and low on the DONE cycle.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    @(negedge CLK);
    START = 1'b1; ALU_OP = op; DATA1 = a; DATA2 = b;
    lat = -1; stall_ok = 1'b1; res = '0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (DONE) begin
        lat = c; res = RESULT;
        if (STALL) stall_ok = 1'b0;
        break;
      end
      if (!STALL) stall_ok = 1'b0;
      @(negedge CLK);
    end
    START = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, prior;
    int          lat, d1, d2, cyc;
    bit          stall_ok, seen;

    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{OP_REMU,   32'd7,        32'd2,        32'd1,        33};
    vecs[7]  = '{OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 33};
    vecs[8]  = '{OP_MULHU,  32'h80000000, 32'd4,        32'd2,        33};
    vecs[9]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[10] = '{OP_MULHSU, 32'h80000000, 32'd2,        32'hFFFFFFFF, 33};
    vecs[11] = '{OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[12] = '{OP_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        33};
    vecs[13] = '{OP_REMU,   32'hFFFFFFFF, 32'd10,       32'd5,        33};
    vecs[14] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[15] = '{OP_DIV,    32'd9,        32'd0,        32'hFFFFFFFF, 1};
    vecs[16] = '{OP_REM,    32'd5,        32'd0,        32'd5,        1};
    vecs[17] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[18] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; ALU_OP = '0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("reset_stall",  32'(STALL), 32'd0);
    check("reset_done",   32'(DONE),  32'd0);
    check("reset_busy",   32'(BUSY),  32'd0);
    check("reset_result", RESULT,     32'd0);

    // Non-MD ops: no stall, no state change
    @(negedge CLK);
    START = 1'b1; ALU_OP = 5'b00000; DATA1 = 32'd3; DATA2 = 32'd4;
    #1 check("nonmd_stall", 32'(STALL), 32'd0);
    @(negedge CLK);
    #1 check("nonmd_busy", 32'(BUSY), 32'd0);
    ALU_OP = 5'b11110;
    #1 check("fwd_stall", 32'(STALL), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    #1 check("fwd_busy", 32'(BUSY), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, stall_ok);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_stall", i), 32'(stall_ok), 32'd1);
      @(negedge CLK);
      #1 check($sformatf("v%0d_done_drop", i), 32'(DONE), 32'd0);
      check($sformatf("v%0d_result_hold", i), RESULT, vecs[i].exp);
    end
    prior = vecs[NV-1].exp;

    // FLUSH at CALC cycle 10
    @(negedge CLK);
    START = 1'b1; ALU_OP = OP_MUL; DATA1 = 32'h55; DATA2 = 32'h66;
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1; START = 1'b0;
    @(negedge CLK);
    FLUSH = 1'b0;
    #1;
    check("flush_busy",  32'(BUSY),  32'd0);
    check("flush_stall", 32'(STALL), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      #1 if (DONE) seen = 1'b1;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_result_hold", RESULT, prior);
    run_op(OP_MUL, 32'd3, 32'd4, res, lat, stall_ok);
    check("post_flush_mul", res, 32'd12);
    check("post_flush_lat", 32'(lat), 32'd33);

    // RESET at CALC cycle 5
    @(negedge CLK);
    START = 1'b1; ALU_OP = OP_MUL; DATA1 = 32'd9; DATA2 = 32'd9;
    repeat (5) @(negedge CLK);
    #1 check("pre_reset_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1; START = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("mid_reset_stall",  32'(STALL), 32'd0);
    check("mid_reset_done",   32'(DONE),  32'd0);
    check("mid_reset_busy",   32'(BUSY),  32'd0);
    check("mid_reset_result", RESULT,     32'd0);

    // Back-to-back: second op presented on the FIN cycle is accepted next cycle
    @(negedge CLK);
    START = 1'b1; ALU_OP = OP_MUL; DATA1 = 32'd2; DATA2 = 32'd3;
    d1 = -1; d2 = -1; cyc = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (DONE) begin
        if (d1 < 0) begin
          d1 = c;
          check("b2b_first", RESULT, 32'd6);
          DATA1 = 32'd4; DATA2 = 32'd5;
        end else begin
          d2 = c;
          check("b2b_second", RESULT, 32'd20);
          break;
        end
      end
      @(negedge CLK);
    end
    START = 1'b0;
    check("b2b_first_lat", 32'(d1), 32'd33);
    check("b2b_gap", 32'(d2 - d1), 32'd34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
